tt_vfp_result_collect: RTL and testbench

- Sits directly downstream of the vector FP execute unit and turns its parallel result buses into one in-order, flow-controlled result stream for the vector register writeback.
- Non-FMA results are combinational at issue. They are delayed to line up with the FMA_LAT-cycle FMA result, so all results retire in issue order.
- Results are buffered in a FIFO with credit-based issue throttling. The block also keeps a sticky fflags accumulator.

---
 rtl/tt_vfp_result_collect_if.sv | 31 +++
 rtl/tt_vfp_result_collect.sv | 202 ++++++++++++++++++++
 tb/tb_tt_vfp_result_collect.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_vfp_result_collect_if.sv
// -----------------------------------------------------------------------------
// tt_vfp_result_collect_if
// Result stream from the vector FP result collector to the vector register
// writeback. Signal names are kept from the collector's point of view.
//
//   o_valid : result valid (collector -> writeback)
//   i_ready : writeback accepts (writeback -> collector)
//   o_data  : W-bit result, W = expWidth + sigWidth + 1
//   o_tag   : opaque element tag
//   o_exc   : 5-bit exception flags of this result
//
// Modports: master = collector side, slave = writeback side.
// -----------------------------------------------------------------------------
interface tt_vfp_result_collect_if #(
    parameter int expWidth = 5,
    parameter int sigWidth = 11,
    parameter int TAG_W    = 4
);
    localparam int W = expWidth + sigWidth + 1;

    logic             o_valid;
    logic             i_ready;
    logic [W-1:0]     o_data;
    logic [TAG_W-1:0] o_tag;
    logic [4:0]       o_exc;

    modport master (output o_valid, output o_data, output o_tag, output o_exc,
                    input  i_ready);
    modport slave  (input  o_valid, input  o_data, input  o_tag, input  o_exc,
                    output i_ready);
endinterface

// File: rtl/tt_vfp_result_collect.sv
// -----------------------------------------------------------------------------
// tt_vfp_result_collect
// Collects the parallel result buses of the vector FP execute unit into one
// in-order, credit-throttled result stream. Combinational (non-FMA) results are
// captured at issue and delayed through a FMA_LAT-deep alignment pipeline so
// that they retire in issue order with the FMA results, which are substituted
// at pipeline exit. Results are buffered in a FIFO_DEPTH-entry FIFO.
//
// Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_valid / o_ready    issue handshake (o_ready = issue credit available)
//   i_kind, i_tag        operation kind (0..7) and element tag at issue
//   i_fp_res/i_fp_exc    int-to-fp result          (kind 0)
//   i_int_res/i_int_exc  fp-to-int result          (kind 1)
//   i_cmp_lt/eq/exc      compare results           (kinds 2,3,4)
//   i_cls_res            classify mask             (kind 5)
//   i_sel_res/i_sel_exc  min/max result            (kind 6)
//   i_fma_res/i_fma_exc  FMA result, FMA_LAT after issue (kind 7)
//   o_res                result stream (valid/ready/data/tag/exc)
//   o_fflags             sticky OR of retired exception flags
//   i_fflags_clr         synchronous clear of o_fflags
//   o_busy               any op in the pipeline or FIFO
// -----------------------------------------------------------------------------
module tt_vfp_result_collect #(
    parameter int expWidth   = 5,
    parameter int sigWidth   = 11,
    parameter int FMA_LAT    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [2:0]                          i_kind,
    input  logic [TAG_W-1:0]                    i_tag,
    input  logic [expWidth+sigWidth:0]          i_fp_res,
    input  logic [4:0]                          i_fp_exc,
    input  logic [expWidth+sigWidth-1:0]        i_int_res,
    input  logic [4:0]                          i_int_exc,
    input  logic                                i_cmp_lt,
    input  logic                                i_cmp_eq,
    input  logic [4:0]                          i_cmp_exc,
    input  logic [9:0]                          i_cls_res,
    input  logic [expWidth+sigWidth:0]          i_sel_res,
    input  logic [4:0]                          i_sel_exc,
    input  logic [expWidth+sigWidth-1:0]        i_fma_res,
    input  logic [4:0]                          i_fma_exc,
    tt_vfp_result_collect_if.master             o_res,
    output logic [4:0]                          o_fflags,
    input  logic                                i_fflags_clr,
    output logic                                o_busy
);
    localparam int W     = expWidth + sigWidth + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + FMA_LAT + 1);

    typedef enum logic [2:0] {
        K_CVT_FP  = 3'd0,
        K_CVT_INT = 3'd1,
        K_CMP_LT  = 3'd2,
        K_CMP_LE  = 3'd3,
        K_CMP_EQ  = 3'd4,
        K_CLASS   = 3'd5,
        K_MINMAX  = 3'd6,
        K_FMA     = 3'd7
    } kind_e;

    // ---------------------------------------------------------------- issue
    logic             w_issue;
    logic [W-1:0]     w_sel_data;
    logic [4:0]       w_sel_exc;
    logic [OCC_W-1:0] w_occ;

    assign w_issue = i_valid && o_ready;

    always_comb begin
        w_sel_data = '0;
        w_sel_exc  = '0;
        case (kind_e'(i_kind))
            K_CVT_FP:  begin w_sel_data = i_fp_res;          w_sel_exc = i_fp_exc;  end
            K_CVT_INT: begin w_sel_data = {1'b0, i_int_res}; w_sel_exc = i_int_exc; end
            K_CMP_LT:  begin w_sel_data[0] = i_cmp_lt;              w_sel_exc = i_cmp_exc; end
            K_CMP_LE:  begin w_sel_data[0] = i_cmp_lt | i_cmp_eq;   w_sel_exc = i_cmp_exc; end
            K_CMP_EQ:  begin w_sel_data[0] = i_cmp_eq;              w_sel_exc = i_cmp_exc; end
            K_CLASS:   begin w_sel_data[9:0] = i_cls_res; end
            K_MINMAX:  begin w_sel_data = i_sel_res;         w_sel_exc = i_sel_exc; end
            default:   ; // FMA: data/exc substituted at pipeline exit
        endcase
    end

    // ------------------------------------------------- alignment pipeline
    // Stage k holds an op issued k cycles ago; it never stalls because issue
    // credit already reserves a FIFO slot for every op in flight.
    logic [FMA_LAT:1]             r_pv;
    logic [FMA_LAT:1]             r_pk7;
    logic [FMA_LAT:1][TAG_W-1:0]  r_ptag;
    logic [FMA_LAT:1][W-1:0]      r_pdata;
    logic [FMA_LAT:1][4:0]        r_pexc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pv    <= '0;
            r_pk7   <= '0;
            r_ptag  <= '0;
            r_pdata <= '0;
            r_pexc  <= '0;
        end else begin
            r_pv[1]    <= w_issue;
            r_pk7[1]   <= (kind_e'(i_kind) == K_FMA);
            r_ptag[1]  <= i_tag;
            r_pdata[1] <= w_sel_data;
            r_pexc[1]  <= w_sel_exc;
            for (int unsigned k = 2; k <= FMA_LAT; k++) begin
                r_pv[k]    <= r_pv[k-1];
                r_pk7[k]   <= r_pk7[k-1];
                r_ptag[k]  <= r_ptag[k-1];
                r_pdata[k] <= r_pdata[k-1];
                r_pexc[k]  <= r_pexc[k-1];
            end
        end
    end

    logic         w_push;
    logic [W-1:0] w_push_data;
    logic [4:0]   w_push_exc;

    assign w_push      = r_pv[FMA_LAT];
    assign w_push_data = r_pk7[FMA_LAT] ? {1'b0, i_fma_res} : r_pdata[FMA_LAT];
    assign w_push_exc  = r_pk7[FMA_LAT] ? i_fma_exc         : r_pexc[FMA_LAT];

    // ----------------------------------------------------------------- FIFO
    logic [W-1:0]     r_mdata [FIFO_DEPTH];
    logic [TAG_W-1:0] r_mtag  [FIFO_DEPTH];
    logic [4:0]       r_mexc  [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_nempty;
    logic             w_pop;

    assign w_nempty = (r_cnt != '0);
    assign w_pop    = w_nempty && o_res.i_ready;

    // Storage is not reset: every read is gated by a reset-cleared count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mdata[r_wr] <= w_push_data;
            r_mtag[r_wr]  <= r_ptag[FMA_LAT];
            r_mexc[r_wr]  <= w_push_exc;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_res.o_valid = w_nempty;
    assign o_res.o_data  = w_nempty ? r_mdata[r_rd] : '0;
    assign o_res.o_tag   = w_nempty ? r_mtag[r_rd]  : '0;
    assign o_res.o_exc   = w_nempty ? r_mexc[r_rd]  : '0;

    // --------------------------------------------------------------- credit
    // Occupancy from registered state only, so a pop returns its credit in
    // the following cycle.
    always_comb begin
        w_occ = OCC_W'(r_cnt);
        for (int unsigned k = 1; k <= FMA_LAT; k++) begin
            w_occ = w_occ + OCC_W'(r_pv[k]);
        end
    end

    assign o_ready = (w_occ < OCC_W'(FIFO_DEPTH));
    assign o_busy  = (w_occ != '0);

    // --------------------------------------------------------------- fflags
    logic [4:0] r_fflags;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fflags <= '0;
        end else begin
            r_fflags <= (i_fflags_clr ? 5'b0 : r_fflags) | (w_pop ? o_res.o_exc : 5'b0);
        end
    end

    assign o_fflags = r_fflags;

endmodule

// File: tb/tb_tt_vfp_result_collect.sv
module tb_tt_vfp_result_collect;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_kind;
    logic [3:0]  i_tag;
    logic [16:0] i_fp_res;
    logic [4:0]  i_fp_exc;
    logic [15:0] i_int_res;
    logic [4:0]  i_int_exc;
    logic        i_cmp_lt;
    logic        i_cmp_eq;
    logic [4:0]  i_cmp_exc;
    logic [9:0]  i_cls_res;
    logic [16:0] i_sel_res;
    logic [4:0]  i_sel_exc;
    logic [15:0] i_fma_res;
    logic [4:0]  i_fma_exc;
    logic [4:0]  o_fflags;
    logic        i_fflags_clr;
    logic        o_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tt_vfp_result_collect_if #(.expWidth(5), .sigWidth(11), .TAG_W(4)) rif ();

    tt_vfp_result_collect #(
        .expWidth(5), .sigWidth(11), .FMA_LAT(3), .FIFO_DEPTH(4), .TAG_W(4)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_kind(i_kind), .i_tag(i_tag),
        .i_fp_res(i_fp_res), .i_fp_exc(i_fp_exc),
        .i_int_res(i_int_res), .i_int_exc(i_int_exc),
        .i_cmp_lt(i_cmp_lt), .i_cmp_eq(i_cmp_eq), .i_cmp_exc(i_cmp_exc),
        .i_cls_res(i_cls_res),
        .i_sel_res(i_sel_res), .i_sel_exc(i_sel_exc),
        .i_fma_res(i_fma_res), .i_fma_exc(i_fma_exc),
        .o_res(rif.master),
        .o_fflags(o_fflags), .i_fflags_clr(i_fflags_clr), .o_busy(o_busy)
    );

    // One cycle: inputs set and outputs sampled 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = 0; i_kind = 0; i_tag = 0;
        i_fp_res = 0; i_fp_exc = 0; i_int_res = 0; i_int_exc = 0;
        i_cmp_lt = 0; i_cmp_eq = 0; i_cmp_exc = 0; i_cls_res = 0;
        i_sel_res = 0; i_sel_exc = 0; i_fma_res = 0; i_fma_exc = 0;
        i_fflags_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        rif.i_ready = 1;
        #3;
        n_chk++; if (rif.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", rif.o_valid); end
        n_chk++; if (rif.o_data !== 17'h0) begin n_fail++; $display("FAIL reset_o_data: got %h want 0", rif.o_data); end
        n_chk++; if (rif.o_tag !== 4'h0) begin n_fail++; $display("FAIL reset_o_tag: got %h want 0", rif.o_tag); end
        n_chk++; if (rif.o_exc !== 5'h0) begin n_fail++; $display("FAIL reset_o_exc: got %h want 0", rif.o_exc); end
        n_chk++; if (o_fflags !== 5'h0) begin n_fail++; $display("FAIL reset_o_fflags: got %h want 0", o_fflags); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_o_busy: got %b want 0", o_busy); end
        n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    // cmp-le with lt=0, eq=1 -> result 1, visible in cycle 4 only.
    task automatic test_single_cmp_le();
        clear_inputs();
        rif.i_ready = 1;
        for (int c = 0; c <= 6; c++) begin
            i_valid = (c == 0); i_kind = 3'd3; i_cmp_lt = 0; i_cmp_eq = 1; i_cmp_exc = 0; i_tag = 4'd3;
            n_chk++; if (rif.o_valid !== (c == 4)) begin n_fail++; $display("FAIL single_valid c%0d: got %b want %b", c, rif.o_valid, (c == 4)); end
            if (c == 4) begin
                n_chk++; if (rif.o_data !== 17'h00001) begin n_fail++; $display("FAIL single_data: got %h want 00001", rif.o_data); end
                n_chk++; if (rif.o_tag !== 4'd3) begin n_fail++; $display("FAIL single_tag: got %h want 3", rif.o_tag); end
            end
            step();
        end
        clear_inputs();
    endtask

    // FMA then classify: the FMA bus is only correct in cycle 3.
    task automatic test_ordering();
        clear_inputs();
        rif.i_ready = 1;
        for (int c = 0; c <= 6; c++) begin
            i_valid   = (c <= 1);
            i_kind    = (c == 0) ? 3'd7 : 3'd5;
            i_tag     = (c == 0) ? 4'd1 : 4'd2;
            i_cls_res = 10'h040;
            i_fma_res = (c == 3) ? 16'h3C00 : 16'h5A5A;
            i_fma_exc = (c == 3) ? 5'h00 : 5'h1F;
            n_chk++; if (rif.o_valid !== (c == 4 || c == 5)) begin n_fail++; $display("FAIL order_valid c%0d: got %b want %b", c, rif.o_valid, (c == 4 || c == 5)); end
            if (c == 4) begin
                n_chk++; if ({rif.o_data, rif.o_tag, rif.o_exc} !== {17'h03C00, 4'd1, 5'h00}) begin n_fail++; $display("FAIL order_first: got %h/%h/%h want 03c00/1/00", rif.o_data, rif.o_tag, rif.o_exc); end
            end
            if (c == 5) begin
                n_chk++; if ({rif.o_data, rif.o_tag, rif.o_exc} !== {17'h00040, 4'd2, 5'h00}) begin n_fail++; $display("FAIL order_second: got %h/%h/%h want 00040/2/00", rif.o_data, rif.o_tag, rif.o_exc); end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        rif.i_ready = 0;
        i_kind = 3'd1; i_int_res = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            i_valid = 1; i_tag = 4'(i);
            n_chk++; if (o_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_ready issue%0d: got %b want %b", i, o_ready, (i < 4)); end
            step();
        end
        i_valid = 0;
        repeat (4) step();
        n_chk++; if ({rif.o_valid, o_ready, o_busy} !== 3'b101) begin n_fail++; $display("FAIL bp_full: got valid/ready/busy %b%b%b want 101", rif.o_valid, o_ready, o_busy); end
        rif.i_ready = 1;
        for (int j = 0; j < 4; j++) begin
            n_chk++; if ({rif.o_valid, rif.o_data, rif.o_tag} !== {1'b1, 17'h0FFFF, 4'(j)}) begin n_fail++; $display("FAIL bp_pop%0d: got %b/%h/%h want 1/0ffff/%0d", j, rif.o_valid, rif.o_data, rif.o_tag, j); end
            n_chk++; if (o_ready !== (j != 0)) begin n_fail++; $display("FAIL bp_credit%0d: got %b want %b", j, o_ready, (j != 0)); end
            step();
        end
        n_chk++; if ({rif.o_valid, o_busy, o_ready} !== 3'b001) begin n_fail++; $display("FAIL bp_drained: got valid/busy/ready %b%b%b want 001", rif.o_valid, o_busy, o_ready); end
        clear_inputs();
    endtask

    task automatic test_fflags();
        clear_inputs();
        rif.i_ready = 1;
        i_fflags_clr = 1; step(); i_fflags_clr = 0;
        n_chk++; if (o_fflags !== 5'h00) begin n_fail++; $display("FAIL ff_clear0: got %h want 00", o_fflags); end
        for (int c = 0; c <= 6; c++) begin
            i_valid = (c < 2); i_kind = 3'd0; i_tag = 4'(c);
            i_fp_res = 17'h1ABCD; i_fp_exc = (c == 0) ? 5'h10 : 5'h01;
            if (c == 4) begin
                n_chk++; if (rif.o_exc !== 5'h10) begin n_fail++; $display("FAIL ff_exc_a: got %h want 10", rif.o_exc); end
            end
            if (c == 5) begin
                n_chk++; if ({rif.o_exc, o_fflags} !== {5'h01, 5'h10}) begin n_fail++; $display("FAIL ff_exc_b: got exc %h fflags %h want 01/10", rif.o_exc, o_fflags); end
            end
            step();
        end
        n_chk++; if (o_fflags !== 5'h11) begin n_fail++; $display("FAIL ff_sticky: got %h want 11", o_fflags); end
        for (int c = 0; c <= 5; c++) begin
            i_valid = (c == 0); i_kind = 3'd6; i_tag = 4'd7;
            i_sel_res = 17'h12345; i_sel_exc = 5'h04;
            i_fflags_clr = (c == 4);
            if (c == 4) begin
                n_chk++; if ({rif.o_valid, rif.o_data, rif.o_exc} !== {1'b1, 17'h12345, 5'h04}) begin n_fail++; $display("FAIL ff_minmax: got %b/%h/%h want 1/12345/04", rif.o_valid, rif.o_data, rif.o_exc); end
            end
            if (c == 5) begin
                n_chk++; if (o_fflags !== 5'h04) begin n_fail++; $display("FAIL ff_clr_pop: got %h want 04", o_fflags); end
            end
            step();
        end
        i_fflags_clr = 1; step(); i_fflags_clr = 0;
        n_chk++; if (o_fflags !== 5'h00) begin n_fail++; $display("FAIL ff_clear1: got %h want 00", o_fflags); end
        clear_inputs();
    endtask

    // Continuous issue with the writeback always ready: 20 results, in order,
    // none lost and none repeated.
    task automatic test_back_to_back();
        int next_in  = 0;
        int next_out = 0;
        logic acc;
        clear_inputs();
        rif.i_ready = 1;
        i_kind = 3'd1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            i_valid   = (next_in < 20);
            i_tag     = 4'(next_in);
            i_int_res = 16'hC000 | 16'(next_in);
            if (rif.o_valid === 1'b1) begin
                n_chk++;
                if (next_out >= 20) begin
                    n_fail++; $display("FAIL b2b_extra: got tag %h after 20 results want none", rif.o_tag);
                end else if ({rif.o_tag, rif.o_data} !== {4'(next_out), 17'h0C000 | 17'(next_out)}) begin
                    n_fail++; $display("FAIL b2b_result%0d: got %h/%h want %h/%h", next_out, rif.o_tag, rif.o_data, 4'(next_out), 17'h0C000 | 17'(next_out));
                end
                next_out++;
            end
            acc = i_valid && o_ready;
            step();
            if (acc) next_in++;
        end
        n_chk++; if (next_out != 20) begin n_fail++; $display("FAIL b2b_count: got %0d results want 20", next_out); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b want 0", o_busy); end
        clear_inputs();
    endtask

    task automatic test_reset_midop();
        clear_inputs();
        rif.i_ready = 0;
        i_kind = 3'd1; i_int_res = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1; i_tag = 4'(i);
            step();
        end
        i_valid = 0;
        step();
        n_chk++; if ({rif.o_valid, o_busy, o_ready} !== 3'b110) begin n_fail++; $display("FAIL rst_pre: got valid/busy/ready %b%b%b want 110", rif.o_valid, o_busy, o_ready); end
        #2 rst_n = 0;
        #1;
        n_chk++; if ({rif.o_valid, o_busy, o_ready} !== 3'b001) begin n_fail++; $display("FAIL rst_mid: got valid/busy/ready %b%b%b want 001", rif.o_valid, o_busy, o_ready); end
        n_chk++; if ({rif.o_data, rif.o_tag} !== 21'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h/%h want 0/0", rif.o_data, rif.o_tag); end
        @(negedge clk);
        rst_n = 1;
        rif.i_ready = 1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_chk++; if (rif.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale c%0d: got valid %b tag %h want 0", c, rif.o_valid, rif.o_tag); end
        end
        for (int c = 0; c <= 5; c++) begin
            i_valid = (c == 0); i_kind = 3'd4; i_cmp_eq = 1; i_tag = 4'd9;
            n_chk++; if (rif.o_valid !== (c == 4)) begin n_fail++; $display("FAIL rst_fresh_valid c%0d: got %b want %b", c, rif.o_valid, (c == 4)); end
            if (c == 4) begin
                n_chk++; if ({rif.o_data, rif.o_tag} !== {17'h00001, 4'd9}) begin n_fail++; $display("FAIL rst_fresh: got %h/%h want 00001/9", rif.o_data, rif.o_tag); end
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_cmp_le();
        test_ordering();
        test_backpressure();
        test_fflags();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
